// File: rtl/instr_encoder.sv
// instr_encoder: packs A64 operation fields (CBZ, B, MOVZ, CMP, SUBI, ADDI)
// into 32-bit instruction words. The words pass through a first-word
// fall-through FIFO and stream out to the imem write port at sequential byte
// addresses.
// Optional feature macro: INSTR_ENCODER_RANGE_CHECK_EN. When it is defined,
// requests whose fields do not fit are rejected with enc_err_o. When it is not
// defined, the excess bits are silently truncated.
module instr_encoder #(
    parameter int                FIFO_DEPTH = 4,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          enc_valid_i,
    output logic                          enc_ready_o,
    input  logic [2:0]                    enc_op_i,
    input  logic [4:0]                    enc_rd_i,
    input  logic [4:0]                    enc_rn_i,
    input  logic [4:0]                    enc_rm_i,
    input  logic [25:0]                   enc_imm_i,
    input  logic [1:0]                    enc_shift_i,
    input  logic                          addr_clr_i,
    output logic                          imem_wr_valid_o,
    input  logic                          imem_wr_ready_i,
    output logic [ADDR_W-1:0]             imem_wr_addr_o,
    output logic [31:0]                   imem_wr_data_o,
    output logic                          enc_err_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Operation codes, shared with the decode path
    localparam logic [2:0] OP_CBZ  = 3'd0;
    localparam logic [2:0] OP_B    = 3'd1;
    localparam logic [2:0] OP_MOVZ = 3'd2;
    localparam logic [2:0] OP_CMP  = 3'd3;
    localparam logic [2:0] OP_SUBI = 3'd4;
    localparam logic [2:0] OP_ADDI = 3'd5;

    // Fixed opcode fields of each instruction form
    localparam logic [7:0]  OPC_CBZ  = 8'hB4;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
    localparam logic [10:0] OPC_CMP  = 11'b11101011000;
    localparam logic [8:0]  OPC_SUBI = 9'b110100010;
    localparam logic [8:0]  OPC_ADDI = 9'b100100010;

    logic [31:0]       word;
    logic              op_legal;
    logic              range_ok;
    logic              accept;
    logic              push;
    logic              pop;

    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              err_q,    err_d;

    // Pack the request fields into an instruction word and flag illegal ops
    always_comb begin
        word     = '0;
        op_legal = 1'b1;
        case (enc_op_i)
            OP_CBZ:  word = {OPC_CBZ, enc_imm_i[18:0], enc_rd_i};
            OP_B:    word = {OPC_B, enc_imm_i[25:0]};
            OP_MOVZ: word = {OPC_MOVZ, enc_shift_i, enc_imm_i[15:0], enc_rd_i};
            OP_CMP:  word = {OPC_CMP, enc_rm_i, 6'b0, enc_rn_i, 5'd31};
            OP_SUBI: word = {OPC_SUBI, enc_shift_i[0], enc_imm_i[11:0], enc_rn_i, enc_rd_i};
            OP_ADDI: word = {OPC_ADDI, enc_shift_i[0], enc_imm_i[11:0], enc_rn_i, enc_rd_i};
            default: op_legal = 1'b0;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // Reject fields whose significant bits would be lost in the encoding
    always_comb begin
        range_ok = 1'b1;
        case (enc_op_i)
            OP_CBZ:  range_ok = (enc_imm_i[25:19] == {7{enc_imm_i[18]}});
            OP_MOVZ: range_ok = (enc_imm_i[25:16] == '0);
            OP_SUBI,
            OP_ADDI: range_ok = (enc_imm_i[25:12] == '0) && !enc_shift_i[1];
            default: range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    // enc_ready depends only on the occupancy register, never on imem_wr_ready
    assign enc_ready_o     = (count_q != CNT_W'(FIFO_DEPTH));
    assign imem_wr_valid_o = (count_q != '0);
    assign accept          = enc_valid_i && enc_ready_o;
    assign push            = accept && op_legal && range_ok;
    assign pop             = imem_wr_valid_o && imem_wr_ready_i;

    assign imem_wr_data_o  = imem_wr_valid_o ? mem_q[rd_ptr_q] : 32'h0;
    assign imem_wr_addr_o  = addr_q;
    assign enc_err_o       = err_q;
    assign fifo_count_o    = count_q;

    // Next-state logic for the pointers, occupancy, write address and error pulse
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // An address clear overrides the increment of a concurrent pop
        addr_d = addr_q;
        if (addr_clr_i)
            addr_d = BASE_ADDR;
        else if (pop)
            addr_d = addr_q + ADDR_W'(4);
        err_d = accept && !(op_legal && range_ok);
    end

    // Control state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    // FIFO storage has no reset; the output data is masked while the FIFO is empty
    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= word;
    end

endmodule
